// File: rtl/prdec3to8_hold.sv
// prdec3to8_hold: re-expands a priority-encoder index into a one-hot select.
// Each select is held for HOLD cycles (or until ack), then followed by
// a one-cycle dead gap before the next request can be taken.
module prdec3to8_hold #(
  parameter int HOLD = 4,
  parameter int CW   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] A,
  input  logic       Idle,
  input  logic       en,
  input  logic       ack,
  output logic [7:0] Y,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic [2:0] code_q
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // Counter load value: a hold of HOLD cycles ends when the counter reads 0.
  localparam logic [CW-1:0] LP_CNT_INIT = CW'(HOLD - 1);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_y;
  logic          r_busy;
  logic          r_done;
  logic [2:0]    r_code;
  logic          w_accept;
  logic          w_release;
  logic [7:0]    w_onehot;

  assign w_accept  = (r_state == S_IDLE) && en && !Idle;
  // ack wins over the counter; both only matter while holding.
  assign w_release = (r_state == S_HOLD) && (ack || (r_cnt == '0));
  assign w_onehot  = 8'd1 << A;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode: idle -> hold on accept, hold -> gap on release, gap -> idle always.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)  w_next = S_HOLD;
      S_HOLD:  if (w_release) w_next = S_GAP;
      S_GAP:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Registered select, status flags, captured code and hold counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y    <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_code <= '0;
      r_cnt  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_code <= A;
            r_y    <= w_onehot;
            r_busy <= 1'b1;
            r_cnt  <= LP_CNT_INIT;
          end
        end
        S_HOLD: begin
          if (w_release) begin
            r_y    <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_GAP: begin
          r_y    <= '0;
          r_busy <= 1'b0;
        end
        default: begin
          r_y    <= '0;
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  // Ready is the only combinational output: new requests are taken in idle only.
  always_comb begin
    ready = (r_state == S_IDLE);
  end

  assign Y      = r_y;
  assign busy   = r_busy;
  assign done   = r_done;
  assign code_q = r_code;

endmodule

// File: tb/tb_prdec3to8_hold.sv
// Directed bench for prdec3to8_hold with HOLD=4.
module tb_prdec3to8_hold;

  logic       clk;
  logic       rst;
  logic [2:0] A;
  logic       Idle;
  logic       en;
  logic       ack;
  logic [7:0] Y;
  logic       ready;
  logic       busy;
  logic       done;
  logic [2:0] code_q;

  int n_pass  = 0;
  int n_total = 0;

  prdec3to8_hold #(.HOLD(4), .CW(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .A      (A),
    .Idle   (Idle),
    .en     (en),
    .ack    (ack),
    .Y      (Y),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .code_q (code_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input logic [7:0] ey, input logic er,
                         input logic eb, input logic ed, input logic [2:0] ec);
    chk({tag, ".Y"},      Y,             ey);
    chk({tag, ".ready"},  {7'd0, ready}, {7'd0, er});
    chk({tag, ".busy"},   {7'd0, busy},  {7'd0, eb});
    chk({tag, ".done"},   {7'd0, done},  {7'd0, ed});
    chk({tag, ".code_q"}, {5'd0, code_q}, {5'd0, ec});
  endtask

  initial begin
    rst = 1'b1; A = 3'd5; Idle = 1'b0; en = 1'b1; ack = 1'b0;

    // Reset held for two cycles with a live request present.
    tick(); chk_all("rst1", 8'h00, 1, 0, 0, 3'd0);
    tick(); chk_all("rst2", 8'h00, 1, 0, 0, 3'd0);

    // Basic decode of A=3, four-cycle hold; A changes mid-hold are ignored.
    rst = 1'b0; A = 3'd3;
    tick(); chk_all("dec3_c1", 8'h08, 0, 1, 0, 3'd3);
    en = 1'b0; A = 3'd5;
    tick(); chk_all("dec3_c2", 8'h08, 0, 1, 0, 3'd3);
    tick(); chk_all("dec3_c3", 8'h08, 0, 1, 0, 3'd3);
    tick(); chk_all("dec3_c4", 8'h08, 0, 1, 0, 3'd3);
    tick(); chk_all("dec3_done", 8'h00, 0, 0, 1, 3'd3);
    tick(); chk_all("dec3_idle", 8'h00, 1, 0, 0, 3'd3);

    // Gating: Idle=1 blocks, en=0 blocks.
    Idle = 1'b1; A = 3'd7; en = 1'b1;
    tick(); chk_all("gate_idle1", 8'h00, 1, 0, 0, 3'd3);
    tick(); chk_all("gate_idle2", 8'h00, 1, 0, 0, 3'd3);
    Idle = 1'b0; en = 1'b0;
    tick(); chk_all("gate_en0", 8'h00, 1, 0, 0, 3'd3);

    // Back-to-back sweep: accepts every 6 cycles, Y=0 in gap and idle cycles.
    en = 1'b1;
    for (int a = 0; a < 8; a++) begin
      logic [7:0] oh;
      oh = 8'd1 << a;
      A = 3'(a);
      tick(); chk_all($sformatf("sw%0d_h1", a), oh, 0, 1, 0, 3'(a));
      tick(); chk_all($sformatf("sw%0d_h2", a), oh, 0, 1, 0, 3'(a));
      tick(); chk_all($sformatf("sw%0d_h3", a), oh, 0, 1, 0, 3'(a));
      tick(); chk_all($sformatf("sw%0d_h4", a), oh, 0, 1, 0, 3'(a));
      tick(); chk_all($sformatf("sw%0d_gap", a), 8'h00, 0, 0, 1, 3'(a));
      tick(); chk_all($sformatf("sw%0d_idle", a), 8'h00, 1, 0, 0, 3'(a));
    end
    en = 1'b0;

    // Early release: ack on the second hold cycle.
    A = 3'd6; en = 1'b1;
    tick(); chk_all("ack_h1", 8'h40, 0, 1, 0, 3'd6);
    en = 1'b0;
    tick(); chk_all("ack_h2", 8'h40, 0, 1, 0, 3'd6);
    ack = 1'b1;
    tick(); chk_all("ack_done", 8'h00, 0, 0, 1, 3'd6);
    ack = 1'b0;
    tick(); chk_all("ack_idle", 8'h00, 1, 0, 0, 3'd6);

    // ack outside a hold has no effect.
    ack = 1'b1;
    tick(); chk_all("ack_stray", 8'h00, 1, 0, 0, 3'd6);
    ack = 1'b0;

    // Disturbance: A changes mid-hold, then reset during the third hold cycle.
    A = 3'd2; en = 1'b1;
    tick(); chk_all("dist_h1", 8'h04, 0, 1, 0, 3'd2);
    A = 3'd7;
    tick(); chk_all("dist_h2", 8'h04, 0, 1, 0, 3'd2);
    tick(); chk_all("dist_h3", 8'h04, 0, 1, 0, 3'd2);
    rst = 1'b1;
    tick(); chk_all("dist_rst", 8'h00, 1, 0, 0, 3'd0);
    rst = 1'b0;
    tick(); chk_all("post_h1", 8'h80, 0, 1, 0, 3'd7);
    en = 1'b0;
    tick(); chk_all("post_h2", 8'h80, 0, 1, 0, 3'd7);
    tick(); chk_all("post_h3", 8'h80, 0, 1, 0, 3'd7);
    tick(); chk_all("post_h4", 8'h80, 0, 1, 0, 3'd7);
    tick(); chk_all("post_done", 8'h00, 0, 0, 1, 3'd7);
    tick(); chk_all("post_idle", 8'h00, 1, 0, 0, 3'd7);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/prdec3to8_hold.md
Name: prdec3to8_hold

Overview:
- Sequential counterpart of the 8-to-3 priority encoder: accepts an encoded index plus the encoder's Idle flag and re-expands it into a one-hot select on 8 lines.
- Holds each decoded select for a programmable number of cycles, supports early release, and enforces a one-cycle dead gap between selects.
- Sits downstream of the priority encoder, driving one-hot acknowledge/enable lines back to the 8 requesters.

Parameters:
- HOLD, 4, number of cycles a decoded select stays asserted (legal range 1..255).
- CW, 8, width of the internal hold counter (must satisfy 2^CW > HOLD).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous reset, active-high.
- A  input  3  encoded index from the priority encoder (0..7).
- Idle  input  1  encoder Idle flag; 1 means no request present, A is ignored.
- en  input  1  decode enable; requests are accepted only when en=1.
- ack  input  1  early release from the selected requester.
- Y  output  8  registered one-hot select; all zero when inactive.
- ready  output  1  1 when a new request can be accepted this cycle.
- busy  output  1  1 while a select is being held (HOLD state).
- done  output  1  one-cycle pulse marking the end of a hold.
- code_q  output  3  index captured for the current or most recent select.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst). Reset is sampled only on the rising edge of clk.
- Reset values: Y=8'b0, ready=1, busy=0, done=0, code_q=3'd0, counter=0, state=S_IDLE. Reset mid-hold clears Y and counter at that edge; no done pulse is produced.
- Outputs: all are registered except ready, which is decoded combinationally from state (ready = state==S_IDLE).
- Accept condition: state==S_IDLE && en && !Idle. The request is captured at that edge.
- State S_IDLE:
  - On accept: code_q<=A, Y<=(8'b1<<A), busy<=1, counter<=HOLD-1, next state S_HOLD.
  - Otherwise Y stays 0 and the state is unchanged.
- State S_HOLD:
  - Y holds its value; ready=0.
  - If ack==1 or counter==0: Y<=0, busy<=0, done<=1, next state S_GAP.
  - Otherwise counter<=counter-1.
  - ack takes priority over the counter; ack is ignored outside S_HOLD.
- State S_GAP:
  - Y=0, ready=0, done<=0, next state S_IDLE unconditionally.
  - A and Idle are ignored here, so a request present in S_GAP is not accepted.
- Latency and hold length:
  - Y is visible the cycle after the accept edge.
  - With no ack, Y is high for exactly HOLD cycles.
  - With ack, Y deasserts at the edge where ack is sampled high in S_HOLD. The minimum hold is 1 cycle.
- Request rate: minimum spacing between consecutive accepts is HOLD+2 cycles (HOLD + gap + idle).
- Request changes during a hold: A or Idle changing while in S_HOLD or S_GAP has no effect. code_q and Y stay stable.
- en deasserted mid-hold: no effect on the current hold; en only gates new accepts.
- HOLD=1: S_HOLD lasts exactly one cycle because counter starts at 0.
- One-hot invariant: popcount(Y) is always 0 or 1. Y is nonzero iff busy==1. done is never high in the same cycle as Y nonzero.
- code_q retains its value after the hold ends, until the next accept or reset.

Test Plan:
- Reset behaviour: assert rst for 2 cycles with A=5, Idle=0, en=1 -> Y=0, ready=1, busy=0, done=0, code_q=0 throughout reset.
- Basic decode: HOLD=4, A=3, Idle=0, en=1 for one cycle from idle -> Y=8'b00001000 for exactly 4 cycles, then done=1 for 1 cycle, then ready=1 one cycle later; code_q=3.
- Full sweep and back-to-back: sweep A=0..7 back-to-back with Idle=0 held -> each Y=1<<A with no overlap. Accept spacing is 6 cycles at HOLD=4. Y=0 in every gap cycle.
- Gating: Idle=1 with A=7 and en=1, or en=0 with Idle=0 -> no accept, Y stays 0, ready stays 1.
- Early release: A=6 accepted, ack=1 on the 2nd cycle of the hold -> Y=8'b01000000 for 2 cycles, done pulses on the next cycle, counter discarded.
- Mid-operation disturbance: A=2 accepted, then A changes to 7 and rst is pulsed during cycle 3 of the hold -> Y and code_q do not follow the A change; at the rst edge Y=0 and state=S_IDLE, with no done pulse; the next accept works normally.
